// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared widths and parameter legality helpers for sync_fifo_core
package sync_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 2;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // DEPTH must be a power of two so pointer wrap is a plain binary rollover.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af, input int ae);
    return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read/status bundle between a FIFO user (master) and the FIFO (slave)
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              ena;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output ena, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  ena, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x DATA_W storage, synchronous write port, asynchronous read port
module fifo_mem_2p
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_core.sv
// rtl/sync_fifo_core.sv - single-clock FIFO control: pointers, count, flags, sticky errors.
// SYNC_FIFO_FWFT_EN selects first-word fall-through; undefined gives registered 1-cycle reads.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic    clk,
  input  logic    rst,
  sync_fifo_if.slave bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  if (!fifo_params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_core: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc, full, empty;
  logic [DATA_W-1:0] mem_rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    wr_acc      = bus.ena & bus.wr_en & ~full;
    rd_acc      = bus.ena & bus.rd_en & ~empty;
    wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Rejected requests only flag while enabled; a frozen FIFO ignores them silently.
    overflow_d  = overflow_q  | (bus.ena & bus.wr_en & full);
    underflow_d = underflow_q | (bus.ena & bus.rd_en & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[PTR_W-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q[PTR_W-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = empty ? '0 : mem_rdata;
  assign bus.rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
    rd_valid_d = bus.ena ? rd_acc : rd_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb/tb_sync_fifo_core.sv - scoreboard bench for sync_fifo_core, DATA_W=8 DEPTH=8 AF=6 AE=2
module tb_sync_fifo_core;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] exp_q [$];

  sync_fifo_if #(.DATA_W(8), .DEPTH(8)) bus ();

  sync_fifo_core #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_rd(input logic [7:0] e);
    bus.rd_en = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Monitor: a popped word is seen when FWFT shows it with rd_en, or when a registered read lands.
  initial begin : monitor
    bit edge_live;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      edge_live = bus.ena && !rst;
      @(negedge clk);
      if ((FWFT && bus.rd_valid && bus.rd_en && bus.ena) ||
          (!FWFT && bus.rd_valid && edge_live)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", {24'd0, bus.rd_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.ena = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    tick();
    rst = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_unf", bus.underflow, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);

    // 1: fill, then overflow
    for (int i = 0; i < 8; i++) begin
      do_wr(8'h10 + 8'(i));
      chk("t1_count", bus.count, i + 1);
      chk("t1_af", bus.almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    chk("t1_full", bus.full, 1);
    do_wr(8'hAA);
    chk("t1_ovf", bus.overflow, 1);
    chk("t1_count_hold", bus.count, 8);

    // 2: drain in order, then underflow
    for (int i = 0; i < 8; i++) do_rd(8'h10 + 8'(i));
    tick();
    chk("t2_empty", bus.empty, 1);
    chk("t2_count", bus.count, 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t2_unf", bus.underflow, 1);
    chk("t2_rd_data_hold", bus.rd_data, FWFT ? 32'h0 : 32'h17);
    chk("t2_rd_valid", bus.rd_valid, 0);

    // 3: pointer wrap
    for (int i = 0; i < 5; i++) do_wr(8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) do_rd(8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) do_wr(8'h20 + 8'(i));
    chk("t3_full", bus.full, 1);
    for (int i = 0; i < 8; i++) do_rd(8'h20 + 8'(i));
    chk("t3_empty", bus.empty, 1);
    chk("t3_count", bus.count, 0);

    // 4: simultaneous read/write at count=3, empty, full
    do_reset();
    for (int i = 0; i < 3; i++) do_wr(8'h40 + 8'(i));
    bus.rd_en = 1'b1; exp_q.push_back(8'h40);
    do_wr(8'h43);
    bus.rd_en = 1'b0;
    chk("t4_mid_count", bus.count, 3);
    for (int i = 1; i < 4; i++) do_rd(8'h40 + 8'(i));
    chk("t4_mid_drained", bus.count, 0);
    do_reset();
    bus.rd_en = 1'b1;
    do_wr(8'h50);
    bus.rd_en = 1'b0;
    chk("t4_empty_count", bus.count, 1);
    chk("t4_empty_unf", bus.underflow, 1);
    chk("t4_empty_ovf", bus.overflow, 0);
    for (int i = 1; i < 8; i++) do_wr(8'h50 + 8'(i));
    chk("t4_full_pre", bus.count, 8);
    bus.rd_en = 1'b1; exp_q.push_back(8'h50);
    do_wr(8'h99);
    bus.rd_en = 1'b0;
    chk("t4_full_count", bus.count, 7);
    chk("t4_full_ovf", bus.overflow, 1);
    for (int i = 1; i < 8; i++) do_rd(8'h50 + 8'(i));
    chk("t4_full_drained", bus.count, 0);

    // 5: ena low freezes everything
    do_reset();
    for (int i = 0; i < 3; i++) do_wr(8'h60 + 8'(i));
    tick();
    bus.ena = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'hEE;
    repeat (4) tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("t5_count", bus.count, 3);
    chk("t5_ovf", bus.overflow, 0);
    chk("t5_unf", bus.underflow, 0);
    chk("t5_rd_data", bus.rd_data, FWFT ? 32'h60 : 32'h0);
    bus.ena = 1'b1;
    for (int i = 0; i < 3; i++) do_rd(8'h60 + 8'(i));
    chk("t5_drained", bus.count, 0);

    // 6: reset with ena low at count=5 clears data and sticky flags
    tick();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) do_wr(8'h70 + 8'(i));
    chk("t6_pre_count", bus.count, 5);
    chk("t6_pre_unf", bus.underflow, 1);
    bus.ena = 1'b0;
    do_reset();
    bus.ena = 1'b1;
    chk("t6_count", bus.count, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_unf", bus.underflow, 0);
    chk("t6_ovf", bus.overflow, 0);
    chk("t6_rd_data", bus.rd_data, 0);

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
